// File: rtl/lbp_image_host.sv
// Responder side of the gray/lbp engine interface: holds the gray image and the LBP result store.
// Optional build macro: LBP_HOST_CHECKSUM_EN adds a 16-bit running checksum of accepted results.
module lbp_image_host #(
    parameter int IMG_W = 128,
    parameter int IMG_H = 128,
    parameter int AW    = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [AW-1:0] load_addr,
    input  logic [7:0]    load_data,
    input  logic          load_last,
    input  logic [AW:0]   gray_addr,
    input  logic          gray_req,
    output logic          gray_ready,
    output logic [7:0]    gray_data,
    input  logic [AW:0]   lbp_addr,
    input  logic          lbp_valid,
    input  logic [7:0]    lbp_data,
    input  logic          finish,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          done,
    output logic          done_ok,
    output logic [AW:0]   result_cnt,
    output logic          err_oob,
    output logic          err_dup
`ifdef LBP_HOST_CHECKSUM_EN
    ,
    output logic [15:0]   checksum
`endif
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = AW - CW;
    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_H - 1);
    localparam logic [AW:0]   INTERIOR = (AW+1)'((IMG_W - 2) * (IMG_H - 2));

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SERVE, S_DONE} state_t;

    state_t state_reg, state_next;

    logic [7:0]      img_mem [NPIX];
    logic [7:0]      res_mem [NPIX];
    logic [NPIX-1:0] written_reg;
    logic [7:0]      gray_hold_reg;
    logic [7:0]      rd_data_reg;
    logic            done_ok_reg;
    logic [AW:0]     result_cnt_reg;
    logic            err_oob_reg;
    logic            err_dup_reg;

    logic            load_en;
    logic            lbp_acc;
    logic [AW-1:0]   lbp_idx;
    logic            lbp_border;

    assign load_en    = load_valid && (state_reg == S_IDLE || state_reg == S_LOAD) && !reset;
    assign lbp_acc    = lbp_valid && !lbp_addr[AW] && (state_reg == S_SERVE) && !reset;
    assign lbp_idx    = lbp_addr[AW-1:0];
    assign lbp_border = (lbp_idx[CW-1:0] == '0) || (lbp_idx[CW-1:0] == COL_MAX) ||
                        (lbp_idx[AW-1:CW] == '0) || (lbp_idx[AW-1:CW] == ROW_MAX);

    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (load_valid) state_next = load_last ? S_SERVE : S_LOAD;
            S_LOAD:  if (load_valid && load_last) state_next = S_SERVE;
            S_SERVE: if (finish) state_next = S_DONE;
            S_DONE:  state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (load_en) img_mem[load_addr] <= load_data;
        if (lbp_acc) res_mem[lbp_idx] <= lbp_data;
    end

    // Engine read is asynchronous so the pixel follows gray_addr within the cycle;
    // with no request the last served pixel is replayed from the hold register.
    always_comb begin
        gray_data = gray_hold_reg;
        if (gray_req) gray_data = gray_addr[AW] ? 8'h00 : img_mem[gray_addr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) gray_hold_reg <= 8'h00;
        else if (gray_req) gray_hold_reg <= gray_data;
    end

    // Written bitmap masks stale array contents left over from before the last reset.
    for (genvar gi = 0; gi < NPIX; gi++) begin : g_written
        always_ff @(posedge clk) begin
            if (reset) written_reg[gi] <= 1'b0;
            else if (lbp_acc && lbp_idx == AW'(gi)) written_reg[gi] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) rd_data_reg <= 8'h00;
        else       rd_data_reg <= written_reg[rd_addr] ? res_mem[rd_addr] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_cnt_reg <= '0;
            err_oob_reg    <= 1'b0;
            err_dup_reg    <= 1'b0;
            done_ok_reg    <= 1'b0;
        end else begin
            if (lbp_acc && result_cnt_reg != '1) result_cnt_reg <= result_cnt_reg + 1'b1;
            if ((gray_req && gray_addr[AW]) || (state_reg == S_SERVE && lbp_valid && lbp_addr[AW]))
                err_oob_reg <= 1'b1;
            if (lbp_acc && (written_reg[lbp_idx] || lbp_border)) err_dup_reg <= 1'b1;
            done_ok_reg <= (state_reg == S_DONE) && (result_cnt_reg == INTERIOR) &&
                           !err_oob_reg && !err_dup_reg;
        end
    end

`ifdef LBP_HOST_CHECKSUM_EN
    logic [15:0] checksum_reg;
    always_ff @(posedge clk) begin
        if (reset)        checksum_reg <= 16'h0000;
        else if (lbp_acc) checksum_reg <= checksum_reg + {8'h00, lbp_data};
    end
    assign checksum = checksum_reg;
`endif

    assign gray_ready = (state_reg == S_SERVE);
    assign done       = (state_reg == S_DONE);
    assign done_ok    = done_ok_reg;
    assign rd_data    = rd_data_reg;
    assign result_cnt = result_cnt_reg;
    assign err_oob    = err_oob_reg;
    assign err_dup    = err_dup_reg;
endmodule

// File: tb/tb_lbp_image_host.sv
// Randomized bench for lbp_image_host against an array-based reference of image, results and flags.
// Define LBP_HOST_CHECKSUM_EN to also exercise the checksum output.
module tb_lbp_image_host;
    localparam int W = 128;
    localparam int H = 128;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [13:0] load_addr;
    logic [7:0]  load_data;
    logic        load_last;
    logic [14:0] gray_addr;
    logic        gray_req;
    logic        gray_ready;
    logic [7:0]  gray_data;
    logic [14:0] lbp_addr;
    logic        lbp_valid;
    logic [7:0]  lbp_data;
    logic        finish;
    logic [13:0] rd_addr;
    logic [7:0]  rd_data;
    logic        done;
    logic        done_ok;
    logic [14:0] result_cnt;
    logic        err_oob;
    logic        err_dup;
`ifdef LBP_HOST_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    lbp_image_host dut (
        .clk(clk), .reset(reset),
        .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data), .load_last(load_last),
        .gray_addr(gray_addr), .gray_req(gray_req), .gray_ready(gray_ready), .gray_data(gray_data),
        .lbp_addr(lbp_addr), .lbp_valid(lbp_valid), .lbp_data(lbp_data), .finish(finish),
        .rd_addr(rd_addr), .rd_data(rd_data), .done(done), .done_ok(done_ok),
        .result_cnt(result_cnt), .err_oob(err_oob), .err_dup(err_dup)
`ifdef LBP_HOST_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int fail_cnt  = 0;

    // Reference model: what the image and result stores should hold, plus flags and counters.
    logic [7:0]  img_m [N];
    logic [7:0]  res_m [N];
    bit          wr_m  [N];
    int          cnt_m;
    bit          oob_m;
    bit          dup_m;
    logic [15:0] sum_m;

    function automatic bit is_border(input int a);
        int row, col;
        row = a / W;
        col = a % W;
        return (row == 0) || (row == H - 1) || (col == 0) || (col == W - 1);
    endfunction

    function automatic logic [7:0] exp_rd(input int a);
        return wr_m[a] ? res_m[a] : 8'h00;
    endfunction

    task automatic model_lbp(input logic [14:0] a, input logic [7:0] d);
        if (a[14]) oob_m = 1;
        else begin
            if (wr_m[a[13:0]] || is_border(int'(a[13:0]))) dup_m = 1;
            wr_m[a[13:0]]  = 1;
            res_m[a[13:0]] = d;
            if (cnt_m < 32767) cnt_m++;
            sum_m = sum_m + 16'(d);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1; load_valid = 0; load_last = 0; load_addr = 0; load_data = 0;
        gray_req = 0; gray_addr = 0; lbp_valid = 0; lbp_addr = 0; lbp_data = 0;
        finish = 0; rd_addr = 0;
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < N; i++) wr_m[i] = 0;
        cnt_m = 0; oob_m = 0; dup_m = 0; sum_m = 0;
    endtask

    task automatic enter_serve();
        logic [13:0] a;
        logic [7:0]  d;
        a = 14'($urandom);
        d = 8'($urandom);
        @(negedge clk);
        load_valid = 1; load_addr = a; load_data = d; load_last = 1;
        img_m[a] = d;
        @(negedge clk);
        load_valid = 0; load_last = 0;
    endtask

    task automatic lbp_beat(input logic [14:0] a, input logic [7:0] d, input logic fin);
        @(negedge clk);
        lbp_valid = 1; lbp_addr = a; lbp_data = d; finish = fin;
        model_lbp(a, d);
    endtask

    task automatic lbp_idle();
        @(negedge clk);
        lbp_valid = 0; finish = 0;
    endtask

    task automatic check_rd(input logic [13:0] a);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        check_cnt++;
        if (rd_data !== exp_rd(int'(a))) begin
            fail_cnt++;
            $display("FAIL rd_data addr=%0d got=%h exp=%h", a, rd_data, exp_rd(int'(a)));
        end else $display("readback addr=%0d data=%h", a, rd_data);
    endtask

    task automatic test_reset();
        do_reset();
        check_cnt++;
        if ({gray_ready, done, done_ok, err_oob, err_dup} !== 5'b0 || result_cnt !== 15'd0 ||
            rd_data !== 8'h00 || gray_data !== 8'h00) begin
            fail_cnt++;
            $display("FAIL reset_state got rdy=%b done=%b ok=%b oob=%b dup=%b cnt=%0d rd=%h gd=%h exp all zero",
                     gray_ready, done, done_ok, err_oob, err_dup, result_cnt, rd_data, gray_data);
        end else $display("reset state ok");
    endtask

    task automatic test_load();
        logic [13:0] a;
        logic [7:0]  prev;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            load_valid = 1; load_addr = 14'(i); load_data = 8'($urandom); load_last = (i == N - 1);
            img_m[i] = load_data;
            if (i == N - 1) begin
                check_cnt++;
                if (gray_ready !== 1'b0) begin
                    fail_cnt++;
                    $display("FAIL ready_during_load got=%b exp=0", gray_ready);
                end
            end
        end
        @(negedge clk);
        load_valid = 0; load_last = 0;
        check_cnt++;
        if (gray_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL ready_after_last got=%b exp=1", gray_ready);
        end else $display("load complete, gray_ready=1");
        for (int k = 0; k < 20; k++) begin
            a = (k == 0) ? 14'd129 : 14'($urandom);
            gray_req = 1; gray_addr = {1'b0, a};
            #1;
            check_cnt++;
            if (gray_data !== img_m[a]) begin
                fail_cnt++;
                $display("FAIL gray_read addr=%0d got=%h exp=%h", a, gray_data, img_m[a]);
            end else $display("gray read addr=%0d data=%h", a, gray_data);
            @(negedge clk);
        end
        prev = img_m[a];
        gray_req = 0; gray_addr = {1'b0, a ^ 14'h1555};
        #1;
        check_cnt++;
        if (gray_data !== prev) begin
            fail_cnt++;
            $display("FAIL gray_hold got=%h exp=%h", gray_data, prev);
        end else $display("gray hold data=%h", gray_data);
        @(negedge clk);
        load_valid = 1; load_addr = 14'd5; load_data = ~img_m[5]; load_last = 1;
        @(negedge clk);
        load_valid = 0; load_last = 0;
        gray_req = 1; gray_addr = 15'd5;
        #1;
        check_cnt++;
        if (gray_data !== img_m[5] || gray_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL load_in_serve got=%h rdy=%b exp=%h rdy=1", gray_data, gray_ready, img_m[5]);
        end else $display("load in serve ignored");
        @(negedge clk);
        gray_req = 0;
    endtask

    task automatic test_single_result();
        lbp_beat(15'd129, 8'hA5, 1'b0);
        lbp_idle();
        @(negedge clk);
        finish = 1;
        @(negedge clk);
        finish = 0;
        check_cnt++;
        if (done !== 1'b1 || gray_ready !== 1'b0 || result_cnt !== 15'(cnt_m)) begin
            fail_cnt++;
            $display("FAIL single_done got done=%b rdy=%b cnt=%0d exp done=1 rdy=0 cnt=%0d",
                     done, gray_ready, result_cnt, cnt_m);
        end else $display("single result done cnt=%0d", result_cnt);
        check_rd(14'd129);
        check_rd(14'd130);
        check_cnt++;
        if (done_ok !== 1'b0) begin
            fail_cnt++;
            $display("FAIL single_done_ok got=%b exp=0", done_ok);
        end
    endtask

    task automatic test_full_frame();
        int n;
        do_reset();
        check_rd(14'd129);
        enter_serve();
        n = 0;
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++) begin
                n++;
                lbp_beat(15'(r * W + c), 8'($urandom), n == (W - 2) * (H - 2));
            end
        lbp_idle();
        @(negedge clk);
        check_cnt++;
        if (done !== 1'b1 || done_ok !== 1'b1 || err_dup !== 1'b0 || err_oob !== 1'b0 ||
            result_cnt !== 15'(cnt_m)) begin
            fail_cnt++;
            $display("FAIL full_frame got done=%b ok=%b dup=%b oob=%b cnt=%0d exp 1 1 0 0 %0d",
                     done, done_ok, err_dup, err_oob, result_cnt, cnt_m);
        end else $display("full frame done_ok=1 cnt=%0d", result_cnt);
        check_rd(14'd0);
        for (int k = 0; k < 12; k++) check_rd(14'($urandom));
        @(negedge clk);
        lbp_valid = 1; lbp_addr = 15'd129; lbp_data = ~res_m[129];
        @(negedge clk);
        lbp_valid = 0;
        check_cnt++;
        if (result_cnt !== 15'(cnt_m) || err_dup !== 1'b0) begin
            fail_cnt++;
            $display("FAIL done_write_ignored got cnt=%0d dup=%b exp cnt=%0d dup=0", result_cnt, err_dup, cnt_m);
        end
        check_rd(14'd129);
`ifdef LBP_HOST_CHECKSUM_EN
        check_cnt++;
        if (checksum !== sum_m) begin
            fail_cnt++;
            $display("FAIL full_checksum got=%h exp=%h", checksum, sum_m);
        end
`endif
    endtask

    task automatic test_dup();
        logic [7:0] d1, d2;
        int side, pos, a;
        do_reset();
        enter_serve();
        d1 = 8'($urandom); d2 = 8'($urandom);
        lbp_beat(15'd200, d1, 1'b0);
        lbp_beat(15'd200, d2, 1'b0);
        lbp_idle();
        check_cnt++;
        if (err_dup !== 1'b1 || result_cnt !== 15'(cnt_m)) begin
            fail_cnt++;
            $display("FAIL dup_same_addr got dup=%b cnt=%0d exp dup=1 cnt=%0d", err_dup, result_cnt, cnt_m);
        end else $display("duplicate write flagged cnt=%0d", result_cnt);
        @(negedge clk);
        finish = 1;
        @(negedge clk);
        finish = 0;
        @(negedge clk);
        check_cnt++;
        if (done !== 1'b1 || done_ok !== 1'b0) begin
            fail_cnt++;
            $display("FAIL dup_done_ok got done=%b ok=%b exp done=1 ok=0", done, done_ok);
        end
        check_rd(14'd200);
        for (int k = 0; k < 5; k++) begin
            side = (k == 0) ? 0 : int'($urandom_range(3, 0));
            pos  = (k == 0) ? 0 : int'($urandom_range(W - 1, 0));
            case (side)
                0: a = pos;
                1: a = (H - 1) * W + pos;
                2: a = pos * W;
                default: a = pos * W + W - 1;
            endcase
            do_reset();
            enter_serve();
            lbp_beat(15'(a), 8'($urandom), 1'b0);
            lbp_idle();
            check_cnt++;
            if (err_dup !== dup_m || err_dup !== 1'b1) begin
                fail_cnt++;
                $display("FAIL dup_border addr=%0d got=%b exp=1", a, err_dup);
            end else $display("border write addr=%0d flagged", a);
            check_rd(14'(a));
        end
    endtask

    task automatic test_oob();
        logic [14:0] ga;
        do_reset();
        enter_serve();
        ga = 15'h4000 | 15'($urandom_range(16383, 0));
        @(negedge clk);
        gray_req = 1; gray_addr = ga;
        #1;
        check_cnt++;
        if (gray_data !== 8'h00) begin
            fail_cnt++;
            $display("FAIL oob_gray_data addr=%h got=%h exp=00", ga, gray_data);
        end else $display("oob gray read addr=%h data=00", ga);
        @(negedge clk);
        gray_req = 0;
        check_cnt++;
        if (err_oob !== 1'b1) begin
            fail_cnt++;
            $display("FAIL oob_gray_flag got=%b exp=1", err_oob);
        end
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        check_cnt++;
        if (gray_ready !== 1'b0 || err_oob !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_mid_serve got rdy=%b oob=%b exp 0 0", gray_ready, err_oob);
        end else $display("reset mid serve clears ready and oob");
        do_reset();
        enter_serve();
        lbp_beat(15'h4000 | 15'd300, 8'($urandom), 1'b0);
        lbp_idle();
        check_cnt++;
        if (err_oob !== oob_m || result_cnt !== 15'(cnt_m) || err_dup !== 1'b0) begin
            fail_cnt++;
            $display("FAIL oob_lbp got oob=%b cnt=%0d dup=%b exp oob=%b cnt=%0d dup=0",
                     err_oob, result_cnt, err_dup, oob_m, cnt_m);
        end else $display("oob lbp write rejected cnt=%0d", result_cnt);
        check_rd(14'd300);
    endtask

`ifdef LBP_HOST_CHECKSUM_EN
    task automatic test_checksum();
        do_reset();
        enter_serve();
        lbp_beat(15'd129, 8'hFF, 1'b0);
        lbp_beat(15'd130, 8'h02, 1'b0);
        lbp_idle();
        check_cnt++;
        if (checksum !== 16'h0101) begin
            fail_cnt++;
            $display("FAIL checksum_pair got=%h exp=0101", checksum);
        end else $display("checksum after FF,02 = %h", checksum);
        lbp_beat(15'd131, 8'($urandom), 1'b1);
        lbp_idle();
        check_cnt++;
        if (checksum !== sum_m || result_cnt !== 15'(cnt_m) || done !== 1'b1) begin
            fail_cnt++;
            $display("FAIL checksum_finish got sum=%h cnt=%0d done=%b exp sum=%h cnt=%0d done=1",
                     checksum, result_cnt, done, sum_m, cnt_m);
        end else $display("finish-cycle write counted sum=%h", checksum);
    endtask
`endif

    initial begin
        reset = 1;
        test_reset();
        test_load();
        test_single_result();
        test_full_frame();
        test_dup();
        test_oob();
`ifdef LBP_HOST_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", check_cnt, fail_cnt);
        $finish;
    end
endmodule
